// File: rtl/reg_bank.sv
// reg_bank: addressable register array with one synchronous write port,
// two independent registered read ports, per-entry written flags, a
// single-cycle bulk clear and an optional same-cycle write-to-read bypass.
//
// Read port semantics: a read issued with re_k high at edge N presents
// rdata_k/rvalid_k after edge N. They hold until the next edge where re_k
// is high again. rvalid_k reports only write history since the last
// reset/clr and is not a transfer strobe.
module reg_bank #(
    parameter int A      = 8,
    parameter int D      = 8,
    parameter int R      = 256,
    parameter bit BYPASS = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         we,
    input  logic [A-1:0] waddr,
    input  logic [D-1:0] wdata,
    input  logic         clr,
    input  logic         re0,
    input  logic [A-1:0] raddr0,
    output logic [D-1:0] rdata0,
    output logic         rvalid0,
    input  logic         re1,
    input  logic [A-1:0] raddr1,
    output logic [D-1:0] rdata1,
    output logic         rvalid1
);

    // One extra bit so that R = 2^A is representable for range checks.
    localparam logic [A:0] R_LIM = (A+1)'(R);

    logic [D-1:0] mem [R];
    logic [R-1:0] wf;

    logic waddr_ok;
    logic raddr0_ok;
    logic raddr1_ok;
    logic write_ok;
    logic fwd0;
    logic fwd1;

    // Address range checks and bypass qualification; clr drops the write
    // and therefore also suppresses forwarding.
    always_comb begin
        waddr_ok  = ({1'b0, waddr}  < R_LIM);
        raddr0_ok = ({1'b0, raddr0} < R_LIM);
        raddr1_ok = ({1'b0, raddr1} < R_LIM);
        write_ok  = we && !clr && waddr_ok;
        fwd0      = BYPASS && write_ok && (waddr == raddr0);
        fwd1      = BYPASS && write_ok && (waddr == raddr1);
    end

    // Storage and written flags: reset > clr > write.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            for (int i = 0; i < R; i++) begin
                mem[i] <= '0;
            end
            wf <= '0;
        end else if (write_ok) begin
            mem[waddr] <= wdata;
            wf[waddr]  <= 1'b1;
        end
    end

    // Read port 0: registered, samples pre-write contents unless forwarded.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata0  <= '0;
            rvalid0 <= 1'b0;
        end else if (re0) begin
            if (!raddr0_ok) begin
                rdata0  <= '0;
                rvalid0 <= 1'b0;
            end else if (fwd0) begin
                rdata0  <= wdata;
                rvalid0 <= 1'b1;
            end else begin
                rdata0  <= mem[raddr0];
                rvalid0 <= wf[raddr0];
            end
        end
    end

    // Read port 1: same rules as port 0, resolved independently.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata1  <= '0;
            rvalid1 <= 1'b0;
        end else if (re1) begin
            if (!raddr1_ok) begin
                rdata1  <= '0;
                rvalid1 <= 1'b0;
            end else if (fwd1) begin
                rdata1  <= wdata;
                rvalid1 <= 1'b1;
            end else begin
                rdata1  <= mem[raddr1];
                rvalid1 <= wf[raddr1];
            end
        end
    end

endmodule

// File: tb/tb_reg_bank.sv
// tb_reg_bank: directed stimulus against two reg_bank instances sharing
// the same inputs (R=200; one with bypass, one without). Expected read
// results are pushed per port/instance; a monitor pops them on the falling
// edge after each enabled read and otherwise checks that outputs hold.
module tb_reg_bank;

    logic       clk = 1'b0;
    logic       reset;
    logic       we;
    logic [7:0] waddr;
    logic [7:0] wdata;
    logic       clr;
    logic       re0;
    logic [7:0] raddr0;
    logic       re1;
    logic [7:0] raddr1;

    logic [7:0] rdata0_b, rdata1_b, rdata0_n, rdata1_n;
    logic       rvalid0_b, rvalid1_b, rvalid0_n, rvalid1_n;

    // Expected {rvalid, rdata}; _b = bypass instance, _n = no bypass.
    logic [8:0] exp_q0b[$];
    logic [8:0] exp_q1b[$];
    logic [8:0] exp_q0n[$];
    logic [8:0] exp_q1n[$];

    int checks = 0;
    int errors = 0;

    reg_bank #(.A(8), .D(8), .R(200), .BYPASS(1'b1)) dut_b (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .clr(clr), .re0(re0), .raddr0(raddr0), .rdata0(rdata0_b),
        .rvalid0(rvalid0_b), .re1(re1), .raddr1(raddr1), .rdata1(rdata1_b),
        .rvalid1(rvalid1_b)
    );

    reg_bank #(.A(8), .D(8), .R(200), .BYPASS(1'b0)) dut_n (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .clr(clr), .re0(re0), .raddr0(raddr0), .rdata0(rdata0_n),
        .rvalid0(rvalid0_n), .re1(re1), .raddr1(raddr1), .rdata1(rdata1_n),
        .rvalid1(rvalid1_n)
    );

    // Clock
    always #5 clk = ~clk;

    // ---------------- scoreboard / monitor ----------------
    bit         started = 1'b0;
    logic       rst_s   = 1'b0;
    logic       rd0_s   = 1'b0;
    logic       rd1_s   = 1'b0;
    logic [8:0] hold0b  = '0;
    logic [8:0] hold1b  = '0;
    logic [8:0] hold0n  = '0;
    logic [8:0] hold1n  = '0;

    // Remember what the DUT sampled at the rising edge.
    always @(posedge clk) begin
        started <= 1'b1;
        rst_s   <= reset;
        rd0_s   <= re0 & ~reset;
        rd1_s   <= re1 & ~reset;
    end

    task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic pop_chk(input string name, inout logic [8:0] q[$],
                           input logic [8:0] act, output logic [8:0] held);
        logic [8:0] e;
        if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s got unexpected read %h want none", name, act);
            held = act;
        end else begin
            e = q.pop_front();
            chk(name, act, e);
            held = e;
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            if (rst_s) begin
                chk("reset_p0_b", {rvalid0_b, rdata0_b}, 9'h000);
                chk("reset_p1_b", {rvalid1_b, rdata1_b}, 9'h000);
                chk("reset_p0_n", {rvalid0_n, rdata0_n}, 9'h000);
                chk("reset_p1_n", {rvalid1_n, rdata1_n}, 9'h000);
                hold0b = '0; hold1b = '0; hold0n = '0; hold1n = '0;
            end else begin
                if (rd0_s) begin
                    pop_chk("read_p0_b", exp_q0b, {rvalid0_b, rdata0_b}, hold0b);
                    pop_chk("read_p0_n", exp_q0n, {rvalid0_n, rdata0_n}, hold0n);
                end else begin
                    chk("hold_p0_b", {rvalid0_b, rdata0_b}, hold0b);
                    chk("hold_p0_n", {rvalid0_n, rdata0_n}, hold0n);
                end
                if (rd1_s) begin
                    pop_chk("read_p1_b", exp_q1b, {rvalid1_b, rdata1_b}, hold1b);
                    pop_chk("read_p1_n", exp_q1n, {rvalid1_n, rdata1_n}, hold1n);
                end else begin
                    chk("hold_p1_b", {rvalid1_b, rdata1_b}, hold1b);
                    chk("hold_p1_n", {rvalid1_n, rdata1_n}, hold1n);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // One clock of stimulus. e0b/e0n/e1b/e1n are hand-computed expected
    // {rvalid, rdata} for each enabled read on the bypass / plain instance.
    task automatic cyc(input logic w, input logic [7:0] wa, input logic [7:0] wd,
                       input logic c,
                       input logic r0, input logic [7:0] a0,
                       input logic [8:0] e0b, input logic [8:0] e0n,
                       input logic r1, input logic [7:0] a1,
                       input logic [8:0] e1b, input logic [8:0] e1n);
        we = w; waddr = wa; wdata = wd; clr = c;
        re0 = r0; raddr0 = a0; re1 = r1; raddr1 = a1;
        if (r0 && !reset) begin
            exp_q0b.push_back(e0b);
            exp_q0n.push_back(e0n);
        end
        if (r1 && !reset) begin
            exp_q1b.push_back(e1b);
            exp_q1n.push_back(e1n);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 8'd0, 9'h0, 9'h0, 1'b0, 8'd0, 9'h0, 9'h0);
    endtask

    task automatic write(input logic [7:0] wa, input logic [7:0] wd);
        cyc(1'b1, wa, wd, 1'b0, 1'b0, 8'd0, 9'h0, 9'h0, 1'b0, 8'd0, 9'h0, 9'h0);
    endtask

    task automatic read2(input logic [7:0] a0, input logic [8:0] e0,
                         input logic [7:0] a1, input logic [8:0] e1);
        cyc(1'b0, 8'd0, 8'd0, 1'b0, 1'b1, a0, e0, e0, 1'b1, a1, e1, e1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset = 1'b1; we = 1'b0; waddr = '0; wdata = '0; clr = 1'b0;
        re0 = 1'b0; raddr0 = '0; re1 = 1'b0; raddr1 = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset then read: nothing written yet.
        read2(8'd5, 9'h000, 8'd5, 9'h000);

        // Write/read, then hold for three idle cycles.
        write(8'd3, 8'hA5);
        read2(8'd3, 9'h1A5, 8'd4, 9'h000);
        repeat (3) idle();

        // Same-cycle collision: bypass forwards 0x22, plain returns 0x11.
        write(8'd7, 8'h11);
        cyc(1'b1, 8'd7, 8'h22, 1'b0, 1'b1, 8'd7, 9'h122, 9'h111,
            1'b1, 8'd7, 9'h122, 9'h111);
        read2(8'd7, 9'h122, 8'd7, 9'h122);

        // clr beats write; same-cycle read sees pre-clear contents.
        write(8'd2, 8'h33);
        cyc(1'b1, 8'd2, 8'h44, 1'b1, 1'b0, 8'd0, 9'h0, 9'h0,
            1'b1, 8'd2, 9'h133, 9'h133);
        read2(8'd2, 9'h000, 8'd7, 9'h000);
        read2(8'd3, 9'h000, 8'd2, 9'h000);

        // Out of range: write ignored, read returns 0, no forwarding.
        cyc(1'b1, 8'd250, 8'hFF, 1'b0, 1'b0, 8'd0, 9'h0, 9'h0,
            1'b1, 8'd250, 9'h000, 9'h000);
        read2(8'd250, 9'h000, 8'd255, 9'h000);
        write(8'd199, 8'h5A);
        read2(8'd199, 9'h15A, 8'd200, 9'h000);
        cyc(1'b1, 8'd199, 8'h6B, 1'b0, 1'b1, 8'd199, 9'h16B, 9'h15A,
            1'b1, 8'd0, 9'h000, 9'h000);
        read2(8'd0, 9'h000, 8'd199, 9'h16B);

        // Reset mid-stream during back-to-back reads.
        write(8'd10, 8'h12);
        write(8'd11, 8'h34);
        read2(8'd10, 9'h112, 8'd11, 9'h134);
        reset = 1'b1;
        read2(8'd11, 9'h000, 8'd10, 9'h000);
        reset = 1'b0;
        read2(8'd10, 9'h000, 8'd11, 9'h000);
        read2(8'd199, 9'h000, 8'd3, 9'h000);
        repeat (2) idle();

        chk("queues_drained", 9'(exp_q0b.size() + exp_q1b.size()
                                 + exp_q0n.size() + exp_q1n.size()), 9'h000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #100000;
        errors++;
        $display("FAIL timeout got running want finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_bank.md
# reg_bank

Parametrised register bank: R entries of D bits, one synchronous write port and two independent registered read ports, with per-entry written flags, a single-cycle bulk clear and an optional write-to-read bypass. It generalises the team's single load-enabled register into an addressable storage array. It sits between datapath producers and consumers that need several named values held across cycles.

## Interface

- A, 8, address width
- D, 8, data width
- R, 256, number of implemented entries; legal range 1..2^A
- BYPASS, 1, 1 = same-cycle write data forwarded to a matching read; 0 = read returns pre-write contents
- clk  in  1  clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high reset
- we  in  1  write enable
- waddr  in  A  write address
- wdata  in  D  write data
- clr  in  1  bulk clear of all entries and written flags
- re0  in  1  read enable, port 0
- raddr0  in  A  read address, port 0
- rdata0  out  D  registered read data, port 0
- rvalid0  out  1  entry had been written since last reset/clr, port 0
- re1  in  1  read enable, port 1
- raddr1  in  A  read address, port 1
- rdata1  out  D  registered read data, port 1
- rvalid1  out  1  as rvalid0, port 1

## Operation

- Storage: mem[0..R-1], D bits each; written flag wf[0..R-1].
- Priority at each edge: reset > clr > write.
- reset high: all mem = 0, all wf = 0, rdata0/1 = 0, rvalid0/1 = 0; we, clr, re ignored.
- clr high (reset low): all mem = 0, all wf = 0 at this edge; a write in the same cycle is dropped. Reads enabled in the same cycle return pre-clear contents; bypass suppressed.
- Write: we high, waddr < R, clr low → mem[waddr] = wdata, wf[waddr] = 1.
- waddr ≥ R: write ignored, no state change.
- Read port k, re_k high, raddr_k < R:
  - rdata_k = mem[raddr_k], rvalid_k = wf[raddr_k], sampled before this edge's write.
  - BYPASS=1 and valid write (we, waddr==raddr_k, waddr < R, clr low): rdata_k = wdata, rvalid_k = 1.
- re_k high, raddr_k ≥ R: rdata_k = 0, rvalid_k = 0.
- re_k low: rdata_k and rvalid_k hold their previous values.
- Both ports may address the same entry, including the write address; each port resolves independently under the same rules.
- rvalid only reports write history; unwritten entries still read as 0.

## Timing

- Write latency 1 cycle: data is in mem after the edge where we is sampled.
- Read latency 1 cycle: address sampled at edge N, rdata/rvalid valid after edge N and stable until the next enabled read.
- Read-after-write to the same address, next cycle: returns new data regardless of BYPASS.
- Same-cycle read/write collision:
  - BYPASS=1 returns new data.
  - BYPASS=0 returns old data and old wf.
- No combinational path from any input to any output.
- Reset release: first write or read takes effect at the first edge with reset low.
- Reset asserted mid-stream: pending read results are discarded and outputs go to 0 at that edge.

## Test plan

- Reset then read: assert reset 2 cycles; re0=1, raddr0=5 → rdata0=0x00, rvalid0=0.
- Write/read: we=1, waddr=3, wdata=0xA5; next cycle re0=1, raddr0=3 → one cycle later rdata0=0xA5, rvalid0=1. Then re0=0 for 3 cycles → rdata0 holds 0xA5.
- Collision, BYPASS=1: mem[7]=0x11; same cycle we=1, waddr=7, wdata=0x22, re0/re1 at 7 → rdata0=rdata1=0x22. Repeat with BYPASS=0 → both 0x11, then 0x22 on the next read.
- clr vs write: mem[2]=0x33; same cycle clr=1, we=1, waddr=2, wdata=0x44, re1 at 2 → rdata1=0x33; next read of 2 → 0x00, rvalid=0.
- Out of range (R=200): write 0xFF to 250 → ignored; read 250 → 0x00, rvalid=0; read 199 after writing 0x5A → 0x5A.
- Reset mid-stream: back-to-back reads of written entries, assert reset for one cycle → outputs 0 at that edge; all entries read 0 with rvalid=0 afterwards.
